// File: rtl/lcd_spi_lshift.sv
// lcd_spi_lshift: parallel-to-serial word shifter and CPOL=1/CPHA=1 SPI clock
// generator for the static-screen LCD path.
// Latency: CLK_DIV*(2*SIZE+1) clk cycles from acceptance to the done pulse.
// Backpressure: one transfer at a time; start is taken only while ready=1,
// and a start seen while busy is dropped, not queued.
//
// Ports:
//   clk      system clock, rising-edge
//   rst_n    asynchronous active-low reset; aborts a transfer without done
//   start    transfer request, accepted when ready=1
//   data_in  word to send, sampled on acceptance
//   dc_in    D/C for the word (0 = command, 1 = data), sampled on acceptance
//   ready    idle, can accept start
//   done     one-cycle pulse at end of transfer
//   sck      serial clock, idles high
//   cs_n     LCD chip select, active-low
//   dc       registered D/C, held until the next acceptance
//   data_s   left-shifting word; downstream stage takes data_s[SIZE-1] on
//            each falling sck edge
//
// Build option: define LCD_SPI_LSB_FIRST_EN to load the word bit-reversed so
// it leaves LSB first. Timing is the same in both builds.

module lcd_spi_lshift #(
  parameter int SIZE    = 8,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] data_in,
  input  logic            dc_in,
  output logic            ready,
  output logic            done,
  output logic            sck,
  output logic            cs_n,
  output logic            dc,
  output logic [SIZE-1:0] data_s
);

  localparam int HP_W  = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(SIZE + 1);

  // Terminal count of the half-period counter: CLK_DIV cycles per phase.
  localparam logic [HP_W-1:0]  HP_LAST   = HP_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FULL  = BIT_W'(SIZE);
  localparam logic [BIT_W-1:0] BIT_FINAL = BIT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [HP_W-1:0]   r_hp_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_ready;
  logic              r_done;
  logic              r_sck;
  logic              r_cs_n;
  logic              r_dc;
  logic [SIZE-1:0]   r_data_s;

  state_t            w_state;
  logic [HP_W-1:0]   w_hp_cnt;
  logic [BIT_W-1:0]  w_bit_cnt;
  logic              w_ready;
  logic              w_done;
  logic              w_sck;
  logic              w_cs_n;
  logic              w_dc;
  logic [SIZE-1:0]   w_data_s;
  logic [SIZE-1:0]   w_load_word;
  logic              w_hp_last;

  // Word as it enters the shift register.
`ifdef LCD_SPI_LSB_FIRST_EN
  always_comb begin
    w_load_word = '0;
    for (int k = 0; k < SIZE; k++) begin
      w_load_word[k] = data_in[SIZE-1-k];
    end
  end
`else
  always_comb begin
    w_load_word = data_in;
  end
`endif

  assign w_hp_last = (r_hp_cnt == HP_LAST);

  always_comb begin
    w_state   = r_state;
    w_hp_cnt  = r_hp_cnt;
    w_bit_cnt = r_bit_cnt;
    w_ready   = r_ready;
    w_done    = 1'b0;
    w_sck     = r_sck;
    w_cs_n    = r_cs_n;
    w_dc      = r_dc;
    w_data_s  = r_data_s;

    case (r_state)
      ST_IDLE: begin
        w_hp_cnt = '0;
        w_sck    = 1'b1;
        if (start) begin
          w_data_s = w_load_word;
          w_dc     = dc_in;
          w_cs_n   = 1'b0;
          w_ready  = 1'b0;
          w_state  = ST_SETUP;
        end
      end

      // cs_n-to-first-sck setup: one full half-period with sck high.
      ST_SETUP: begin
        if (w_hp_last) begin
          w_hp_cnt  = '0;
          w_sck     = 1'b0;
          w_bit_cnt = BIT_FULL;
          w_state   = ST_SHIFT;
        end else begin
          w_hp_cnt = r_hp_cnt + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (w_hp_last) begin
          w_hp_cnt = '0;
          w_sck    = ~r_sck;
          // Shift only as sck rises, so data_s is stable through the whole
          // high phase ahead of the downstream falling-edge register.
          if (!r_sck) begin
            w_data_s  = {r_data_s[SIZE-2:0], 1'b0};
            w_bit_cnt = r_bit_cnt - 1'b1;
            if (r_bit_cnt == BIT_FINAL) begin
              w_state = ST_HOLD;
            end
          end
        end else begin
          w_hp_cnt = r_hp_cnt + 1'b1;
        end
      end

      // Last rising edge to cs_n release: one half-period with sck high.
      ST_HOLD: begin
        if (w_hp_last) begin
          w_hp_cnt = '0;
          w_cs_n   = 1'b1;
          w_done   = 1'b1;
          w_ready  = 1'b1;
          w_state  = ST_IDLE;
        end else begin
          w_hp_cnt = r_hp_cnt + 1'b1;
        end
      end

      default: begin
        w_hp_cnt = '0;
        w_sck    = 1'b1;
        w_cs_n   = 1'b1;
        w_ready  = 1'b1;
        w_state  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_hp_cnt  <= '0;
      r_bit_cnt <= '0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_sck     <= 1'b1;
      r_cs_n    <= 1'b1;
      r_dc      <= 1'b0;
      r_data_s  <= '0;
    end else begin
      r_state   <= w_state;
      r_hp_cnt  <= w_hp_cnt;
      r_bit_cnt <= w_bit_cnt;
      r_ready   <= w_ready;
      r_done    <= w_done;
      r_sck     <= w_sck;
      r_cs_n    <= w_cs_n;
      r_dc      <= w_dc;
      r_data_s  <= w_data_s;
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign sck    = r_sck;
  assign cs_n   = r_cs_n;
  assign dc     = r_dc;
  assign data_s = r_data_s;

endmodule

// File: tb/tb_lcd_spi_lshift.sv
// Directed bench for lcd_spi_lshift (SIZE=8, CLK_DIV=4).
// Models the downstream MSB-extract register on falling sck and collects the
// bit the LCD would see on each rising sck.

module tb_lcd_spi_lshift;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] data_in;
  logic       dc_in;
  logic       ready;
  logic       done;
  logic       sck;
  logic       cs_n;
  logic       dc;
  logic [7:0] data_s;

  int checks   = 0;
  int failures = 0;

  logic       mosi;
  logic [7:0] bits;
  int         rise_cnt;
  int         fall_cnt;
  int         done_cnt;
  int         align_err;
  time        last_chg_t;

`ifdef LCD_SPI_LSB_FIRST_EN
  localparam logic [7:0] EXP_LOAD_01 = 8'h80;
  localparam logic [7:0] EXP_LOAD_80 = 8'h01;
  localparam logic [7:0] EXP_BITS_01 = 8'h80;
  localparam logic [7:0] EXP_BITS_80 = 8'h01;
`else
  localparam logic [7:0] EXP_LOAD_01 = 8'h01;
  localparam logic [7:0] EXP_LOAD_80 = 8'h80;
  localparam logic [7:0] EXP_BITS_01 = 8'h01;
  localparam logic [7:0] EXP_BITS_80 = 8'h80;
`endif

  lcd_spi_lshift #(.SIZE(8), .CLK_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .dc_in   (dc_in),
    .ready   (ready),
    .done    (done),
    .sck     (sck),
    .cs_n    (cs_n),
    .dc      (dc),
    .data_s  (data_s)
  );

  always #5 clk = ~clk;

  // Downstream MSB-extract stage plus a check that data_s was quiet for the
  // CLK_DIV cycles (40 ns) before every falling sck.
  always @(negedge sck or negedge rst_n) begin
    if (!rst_n) begin
      mosi <= 1'b0;
    end else begin
      mosi <= data_s[7];
      fall_cnt++;
      if ($time - last_chg_t < 40) align_err++;
    end
  end

  // What the LCD samples on rising sck.
  always @(posedge sck) begin
    if (rst_n) begin
      bits <= {bits[6:0], mosi};
      rise_cnt++;
    end
  end

  always @(data_s) last_chg_t = $time;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rise_cnt  = 0;
    fall_cnt  = 0;
    done_cnt  = 0;
    align_err = 0;
    bits      = 8'h00;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    data_in    = 8'h00;
    dc_in      = 1'b0;
    last_chg_t = 0;
    clear_mon();

    // ---- reset state ----
    step(3);
    chk("rst_ready",  32'(ready),  32'd1);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_sck",    32'(sck),    32'd1);
    chk("rst_cs_n",   32'(cs_n),   32'd1);
    chk("rst_dc",     32'(dc),     32'd0);
    chk("rst_data_s", 32'(data_s), 32'h00);
    rst_n = 1'b1;
    step(2);

    // ---- single word A5, dc=1 ----
    clear_mon();
    start = 1'b1; data_in = 8'hA5; dc_in = 1'b1;
    step(1);                                   // edge 0
    start = 1'b0;
    chk("sw_accept_cs_n",  32'(cs_n),   32'd0);
    chk("sw_accept_ready", 32'(ready),  32'd0);
    chk("sw_accept_dc",    32'(dc),     32'd1);
    chk("sw_load",         32'(data_s), 32'hA5);
    step(3);                                   // edge 3
    chk("sw_sck_setup",    32'(sck),    32'd1);
    step(1);                                   // edge 4
    chk("sw_sck_fall0",    32'(sck),    32'd0);
    step(63);                                  // edge 67
    chk("sw_e67_done",     32'(done),   32'd0);
    chk("sw_e67_cs_n",     32'(cs_n),   32'd0);
    chk("sw_e67_sck",      32'(sck),    32'd1);
    chk("sw_e67_data_s",   32'(data_s), 32'h00);
    chk("sw_e67_dc",       32'(dc),     32'd1);
    step(1);                                   // edge 68
    chk("sw_done",         32'(done),   32'd1);
    chk("sw_end_cs_n",     32'(cs_n),   32'd1);
    chk("sw_end_ready",    32'(ready),  32'd1);
    chk("sw_bits",         32'(bits),   32'hA5);
    chk("sw_rises",        32'(rise_cnt), 32'd8);
    chk("sw_falls",        32'(fall_cnt), 32'd8);
    chk("sw_align",        32'(align_err), 32'd0);
    step(1);                                   // edge 69
    chk("sw_done_pulse",   32'(done),   32'd0);
    chk("sw_dc_hold",      32'(dc),     32'd1);
    step(2);

    // ---- busy ignore: FF pulsed during 3C ----
    clear_mon();
    start = 1'b1; data_in = 8'h3C; dc_in = 1'b0;
    step(1);                                   // edge 0
    start = 1'b0;
    chk("bz_accept_dc",    32'(dc),     32'd0);
    step(10);                                  // edge 10
    start = 1'b1; data_in = 8'hFF; dc_in = 1'b1;
    step(1);                                   // edge 11
    start = 1'b0;
    chk("bz_data_s_e11",   32'(data_s), 32'h78);
    chk("bz_dc_e11",       32'(dc),     32'd0);
    step(57);                                  // edge 68
    chk("bz_done",         32'(done),   32'd1);
    step(2);
    chk("bz_done_cnt",     32'(done_cnt), 32'd1);
    chk("bz_bits",         32'(bits),   32'h3C);
    chk("bz_ready",        32'(ready),  32'd1);
    chk("bz_cs_n",         32'(cs_n),   32'd1);
    step(2);

    // ---- back-to-back: start held, 01 then 80 ----
    clear_mon();
    start = 1'b1; data_in = 8'h01; dc_in = 1'b0;
    step(1);                                   // edge 0
    chk("bb_load1",        32'(data_s), 32'(EXP_LOAD_01));
    data_in = 8'h80;
    step(68);                                  // edge 68
    chk("bb_done1",        32'(done),   32'd1);
    chk("bb_gap_cs_n",     32'(cs_n),   32'd1);
    chk("bb_bits1",        32'(bits),   32'(EXP_BITS_01));
    clear_mon();
    step(1);                                   // edge 69: second acceptance
    start = 1'b0;
    chk("bb_acc2_cs_n",    32'(cs_n),   32'd0);
    chk("bb_acc2_ready",   32'(ready),  32'd0);
    chk("bb_load2",        32'(data_s), 32'(EXP_LOAD_80));
    step(68);                                  // edge 137
    chk("bb_done2",        32'(done),   32'd1);
    chk("bb_bits2",        32'(bits),   32'(EXP_BITS_80));
    chk("bb_rises2",       32'(rise_cnt), 32'd8);
    step(2);

    // ---- reset mid-SHIFT at cycle 20 ----
    clear_mon();
    start = 1'b1; data_in = 8'hA5; dc_in = 1'b1;
    step(1);                                   // edge 0
    start = 1'b0;
    step(20);                                  // edge 20
    chk("mr_pre_cs_n",     32'(cs_n),   32'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_ready",        32'(ready),  32'd1);
    chk("mr_done",         32'(done),   32'd0);
    chk("mr_sck",          32'(sck),    32'd1);
    chk("mr_cs_n",         32'(cs_n),   32'd1);
    chk("mr_dc",           32'(dc),     32'd0);
    chk("mr_data_s",       32'(data_s), 32'h00);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("mr_release_ready", 32'(ready), 32'd1);
    step(70);
    chk("mr_no_done",      32'(done_cnt), 32'd0);
    chk("mr_idle_cs_n",    32'(cs_n),   32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_spi_lshift.md
# lcd_spi_lshift

Byte serializer and SPI clock generator for the static-screen LCD path. Accepts a parallel word plus a data/command flag on a start/ready handshake, drives chip-select, D/C and a CPOL=1/CPHA=1 serial clock `sck`, and presents the left-shifting word `data_s`. The downstream MSB-extract stage registers `data_s[SIZE-1]` on each falling `sck` edge to drive the LCD DIN/MOSI pin. The LCD samples on rising `sck`.

## Interface
Parameters:
- `SIZE`, 8, word width in bits; must match the downstream MSB-extract stage.
- `CLK_DIV`, 4, `sck` half-period in `clk` cycles; ≥1.

Ports:
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: transfer request; accepted only while `ready`=1.
- `data_in` input SIZE: word to send; sampled on acceptance.
- `dc_in` input 1: D/C value for the word (0 = command, 1 = data); sampled on acceptance.
- `ready` output 1: idle, can accept `start`.
- `done` output 1: one-cycle pulse at the end of a transfer.
- `sck` output 1: serial clock; idles high.
- `cs_n` output 1: LCD chip select, active-low.
- `dc` output 1: registered D/C to the LCD.
- `data_s` output SIZE: shift register; feeds the MSB-extract stage.

## Operation
- All outputs are registered.
- Reset values: `ready`=1, `done`=0, `sck`=1, `cs_n`=1, `dc`=0, `data_s`=0, state IDLE, counters 0.
- `rst_n` low mid-transfer aborts the transfer immediately, with no `done`.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- **IDLE**
  - `ready`=1, `sck`=1, `cs_n`=1.
  - On `start`=1: load `data_s`←`data_in`, `dc`←`dc_in`, `cs_n`←0, `ready`←0, go to SETUP.
  - `start` while not in IDLE is ignored, not queued.
- **SETUP**
  - Hold for CLK_DIV cycles (cs-to-sck setup).
  - Then `sck`←0, load the bit counter with SIZE, go to SHIFT.
- **SHIFT**
  - A half-period counter toggles `sck` every CLK_DIV cycles.
  - On the clk edge where `sck` goes 0→1:
    - `data_s` ← `{data_s[SIZE-2:0],1'b0}`.
    - Bit counter decrements.
  - `data_s` therefore changes only while `sck` rises. It is stable for the whole high phase before the next falling edge, so there is no race with the downstream negedge register.
  - On the rising edge that brings the bit counter to 0, go to HOLD; `sck` stays 1.
  - Exactly SIZE falling and SIZE rising `sck` edges per transfer.
- **HOLD**
  - Hold for CLK_DIV cycles.
  - Then `cs_n`←1, `done`←1 (one cycle), `ready`←1, go to IDLE.
- `dc` holds its value after the transfer until the next acceptance.

## Timing
- Edge 0 is the edge where `start` is accepted; it produces `cs_n`=0 and `ready`=0.
- Falling edge of bit i (i=0..SIZE-1): edge CLK_DIV·(2i+1).
- Rising edge of bit i: edge CLK_DIV·(2i+2).
- `done`/`cs_n`=1/`ready`=1 edge: CLK_DIV·(2·SIZE+1).
- Defaults (SIZE=8, CLK_DIV=4): 68 cycles from acceptance to `done`.
- Back-to-back transfers: `start` may be held high. A new word is accepted on the first edge where `ready`=1, one cycle after `done`. `cs_n` is high for at least that one cycle.
- Counter widths: `$clog2(CLK_DIV+1)` bits (half-period) and `$clog2(SIZE+1)` bits (bit count). No wrap inside a transfer.

## Configuration
- `LCD_SPI_LSB_FIRST_EN` defined:
  - On acceptance, `data_s` loads the bit-reversed word (`data_s[k]`←`data_in[SIZE-1-k]`).
  - The word is emitted LSB first; the shift direction is unchanged.
- Not defined: direct load, MSB first.
- Timing is identical in both builds.

## Test plan
- Reset: assert `rst_n`=0 mid-SHIFT at cycle 20 → all outputs return to reset values immediately and `done` never pulses. Release → `ready`=1 next edge.
- Single word: `data_in`=8'hA5, `dc_in`=1, CLK_DIV=4 → bits sampled on rising `sck` (via the downstream stage) = 1,0,1,0,0,1,0,1; 8 rising edges; `dc`=1 throughout; `done` at edge 68.
- Shift alignment: for every falling `sck`, `data_s` is unchanged for the preceding CLK_DIV cycles. After the last rise, `data_s`=8'h00.
- Busy ignore: pulse `start` with 8'hFF at cycle 10 during an 8'h3C transfer → output remains 8'h3C; exactly one `done`.
- Back-to-back: `start` held high with 8'h01 then 8'h80 → second acceptance one cycle after the first `done`; `cs_n` high for exactly 1 cycle between words.
- Build with `LCD_SPI_LSB_FIRST_EN`, `data_in`=8'h01 → first sampled bit 1, remaining seven 0; `data_s` after load = 8'h80.
